// File: rtl/systolic_feeder.sv
// Operand feeder for the systolic array: stores an A/B matrix pair and streams
// diagonally skewed, zero-padded lane vectors. Optional stall: SYSTOLIC_FEEDER_STALL_EN.
module systolic_feeder #(
  parameter int ARRAY_SIZE = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic                             wr_sel,
  input  logic [$clog2(ARRAY_SIZE)-1:0]    wr_row,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
  input  logic                             start,
  input  logic                             stall,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_out,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_out,
  output logic                             valid_out,
  output logic                             busy,
  output logic                             done,
  output logic                             wr_err
);

  localparam int N         = ARRAY_SIZE;
  localparam int LAST_BEAT = 3 * N - 3;
  localparam int CNT_W     = $clog2(LAST_BEAT + 1);

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             t;
  logic                         finishing;
  elem_t                        mem_a [N][N];
  elem_t                        mem_b [N][N];
  logic [N*DATA_WIDTH-1:0]      a_beat;
  logic [N*DATA_WIDTH-1:0]      b_beat;
  logic                         row_ok;
  logic                         hold;

`ifdef SYSTOLIC_FEEDER_STALL_EN
  assign hold = stall;
`else
  logic stall_unused;
  assign stall_unused = stall;
  assign hold         = 1'b0;
`endif

  assign row_ok = (32'(wr_row) < 32'(N));

  // Lane i of A carries A[i][t-i]; lane j of B carries B[t-j][j]; out-of-range lanes are zero.
  always_comb begin
    a_beat = '0;
    b_beat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (32'(t) == i + k) begin
          a_beat[i*DATA_WIDTH +: DATA_WIDTH] = mem_a[i][k];
          b_beat[i*DATA_WIDTH +: DATA_WIDTH] = mem_b[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      finishing <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          mem_a[r][c] <= '0;
          mem_b[r][c] <= '0;
        end
      end
    end else begin
      wr_err <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          a_out     <= '0;
          b_out     <= '0;
          valid_out <= 1'b0;
          busy      <= 1'b0;
          // finishing marks the cycle after the last beat; done lands here with valid low.
          done      <= finishing;
          finishing <= 1'b0;
          if (wr_en) begin
            if (row_ok) begin
              for (int unsigned k = 0; k < N; k++) begin
                if (wr_sel)
                  mem_b[wr_row][k] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                else
                  mem_a[wr_row][k] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
              end
            end else begin
              wr_err <= 1'b1;
            end
          end else if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
            t     <= '0;
          end
        end
        STREAM: begin
          if (wr_en)
            wr_err <= 1'b1;
          if (hold) begin
            valid_out <= 1'b0;
          end else begin
            a_out     <= a_beat;
            b_out     <= b_beat;
            valid_out <= 1'b1;
            if (t == CNT_W'(LAST_BEAT)) begin
              state     <= IDLE;
              t         <= '0;
              finishing <= 1'b1;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed scoreboard bench for systolic_feeder (N=3, DATA_WIDTH=8).
module tb_systolic_feeder;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic [1:0]   wr_row = '0;
  logic [W-1:0] wr_data = '0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         valid_out;
  logic         busy;
  logic         done;
  logic         wr_err;

  systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .stall(stall), .a_out(a_out), .b_out(b_out),
    .valid_out(valid_out), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } beat_t;

  beat_t       q[$];
  logic [7:0]  ma [N][N];
  logic [7:0]  mb [N][N];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          valid_cnt, done_cnt, err_cnt, done_cyc, last_valid_cyc, first_valid_cyc;
  int          start_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    valid_cnt = 0; done_cnt = 0; err_cnt = 0;
    done_cyc = -1; last_valid_cyc = -1; first_valid_cyc = -1;
  endtask

  // One clock; outputs sampled 1 time unit after the edge, beats checked against the scoreboard.
  task automatic cyc();
    beat_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (valid_out) begin
      valid_cnt++;
      last_valid_cyc = cycle;
      if (first_valid_cyc < 0) first_valid_cyc = cycle;
      if (q.size() == 0) begin
        check("unexpected_beat", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        check("a_lanes", 64'(a_out), 64'(e.a));
        check("b_lanes", 64'(b_out), 64'(e.b));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    if (wr_err) err_cnt++;
  endtask

  task automatic push_expected();
    beat_t e;
    for (int t = 0; t < 3 * N - 2; t++) begin
      e.a = '0;
      e.b = '0;
      for (int l = 0; l < N; l++) begin
        if (t - l >= 0 && t - l < N) begin
          e.a[l*DW +: DW] = ma[l][t-l];
          e.b[l*DW +: DW] = mb[t-l][l];
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic write_row(input logic sel, input logic [1:0] row, input logic [W-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_row = row; wr_data = data;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic load_default();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 8'(1 + 3 * r + c);
        mb[r][c] = 8'(10 + 3 * r + c);
      end
      write_row(1'b0, 2'(r), {ma[r][2], ma[r][1], ma[r][0]});
      write_row(1'b1, 2'(r), {mb[r][2], mb[r][1], mb[r][0]});
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    start_cyc = cycle;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_cnt == 0; i++) cyc();
    check("done_seen", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #2;
    check("rst_a_out", 64'(a_out), 64'd0);
    check("rst_b_out", 64'(b_out), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    #10 rst = 1'b0;

    // Basic stream
    load_default();
    clr_stats();
    push_expected();
    do_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_no_valid_yet", 64'(valid_out), 64'd0);
    wait_done();
    check("basic_beats", 64'(valid_cnt), 64'd7);
    check("basic_first_beat_lat", 64'(first_valid_cyc - start_cyc), 64'd1);
    check("basic_done_after_last", 64'(done_cyc - last_valid_cyc), 64'd1);
    check("basic_done_lat", 64'(done_cyc - start_cyc), 64'd8);
    check("basic_busy_low", 64'(busy), 64'd0);
    check("basic_queue_empty", 64'(q.size()), 64'd0);
    cyc();
    check("done_one_cycle", 64'(done), 64'd0);

    // Write during stream is rejected
    clr_stats();
    push_expected();
    do_start();
    cyc(); cyc(); cyc();
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = 24'hEEEEEE;
    cyc();
    wr_en = 1'b0;
    check("stream_wr_err", 64'(wr_err), 64'd1);
    cyc();
    check("stream_wr_err_pulse", 64'(wr_err), 64'd0);
    wait_done();
    check("stream_wr_beats", 64'(valid_cnt), 64'd7);
    clr_stats();
    push_expected();
    do_start();
    wait_done();
    check("post_reject_queue", 64'(q.size()), 64'd0);

    // Out-of-range row, then start together with a write in IDLE
    clr_stats();
    write_row(1'b0, 2'd3, 24'hABABAB);
    check("bad_row_wr_err", 64'(wr_err), 64'd1);
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_data = {8'd60, 8'd50, 8'd40};
    start = 1'b1;
    cyc();
    wr_en = 1'b0; start = 1'b0;
    ma[1][0] = 8'd40; ma[1][1] = 8'd50; ma[1][2] = 8'd60;
    check("simul_busy", 64'(busy), 64'd0);
    cyc(); cyc();
    check("simul_no_stream", 64'(valid_cnt), 64'd0);
    check("simul_still_idle", 64'(busy), 64'd0);
    push_expected();
    do_start();
    wait_done();
    check("new_data_beats", 64'(valid_cnt), 64'd7);
    check("new_data_queue", 64'(q.size()), 64'd0);

    // Asynchronous reset on beat 3
    clr_stats();
    push_expected();
    do_start();
    cyc(); cyc(); cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    check("arst_a_out", 64'(a_out), 64'd0);
    check("arst_b_out", 64'(b_out), 64'd0);
    check("arst_valid", 64'(valid_out), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    q.delete();
    cyc();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("arst_no_done", 64'(done_cnt), 64'd0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0; mb[r][c] = '0;
      end
    clr_stats();
    push_expected();
    do_start();
    wait_done();
    check("cleared_store_queue", 64'(q.size()), 64'd0);
    load_default();
    clr_stats();
    push_expected();
    do_start();
    cyc();
    check("restart_beat0_a", 64'(a_out), 64'h000001);
    wait_done();
    check("restart_beats", 64'(valid_cnt), 64'd7);

    // Stall for 2 cycles at beat 2
    clr_stats();
    push_expected();
    do_start();
    cyc(); cyc(); cyc();
    stall = 1'b1;
    cyc(); cyc();
    stall = 1'b0;
    wait_done();
    check("stall_beats", 64'(valid_cnt), 64'd7);
    check("stall_queue", 64'(q.size()), 64'd0);
`ifdef SYSTOLIC_FEEDER_STALL_EN
    check("stall_done_lat", 64'(done_cyc - start_cyc), 64'd10);
`else
    check("stall_ignored_done_lat", 64'(done_cyc - start_cyc), 64'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Transmit-side companion to the systolic matrix-multiply array. Holds one ARRAY_SIZE×ARRAY_SIZE operand pair (A, B) written row by row by a host. On `start`, it streams the operands as diagonally skewed, zero-padded lane vectors with a `valid_out` qualifier, in the exact order the array's row and column inputs consume them. It sits between the host/control logic and the array's `a_in`/`b_in`/`valid_in` ports.

## Interface
- `ARRAY_SIZE`, 3: matrix dimension N; number of lanes per operand.
- `DATA_WIDTH`, 8: operand element width.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: write one operand row this cycle.
- `wr_sel`  in  1: 0 = matrix A, 1 = matrix B.
- `wr_row`  in  $clog2(ARRAY_SIZE): row index; values ≥ N are ignored.
- `wr_data`  in  ARRAY_SIZE*DATA_WIDTH: row contents; element k is at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `start`  in  1: begin streaming the stored operands.
- `stall`  in  1: freeze streaming; active only with `SYSTOLIC_FEEDER_STALL_EN`.
- `a_out`  out  ARRAY_SIZE*DATA_WIDTH: A lane vector; lane i feeds array row i.
- `b_out`  out  ARRAY_SIZE*DATA_WIDTH: B lane vector; lane j feeds array column j.
- `valid_out`  out  1: `a_out`/`b_out` carry a stream beat.
- `busy`  out  1: streaming in progress.
- `done`  out  1: one-cycle pulse after the last beat.
- `wr_err`  out  1: one-cycle pulse when a write is rejected.

## Operation
- Storage: two N×N register arrays, A and B. Reset clears them to 0.
- States:
  - IDLE: writes accepted; `start` accepted.
  - STREAM: beat counter t = 0 … 3N−3 (3N−2 beats in total).
  - Transition IDLE→STREAM on `start` with `wr_en` low.
  - Transition STREAM→IDLE after beat 3N−3 is issued; `done` pulses on the following cycle.
- Beat contents:
  - A lane i = A[i][t−i] when 0 ≤ t−i < N, else 0.
  - B lane j = B[t−j][j] when 0 ≤ t−j < N, else 0.
  - Trailing beats, where every lane is out of range, are driven as all zeros with `valid_out` high. They let the array drain.
- `start` and `wr_en` in the same IDLE cycle: the write is committed and `start` is ignored. The host re-asserts `start`.
- `wr_en` during STREAM: storage is unchanged and `wr_err` pulses on the next cycle. `wr_row` ≥ N also causes a rejected write with a `wr_err` pulse.
- `start` during STREAM is ignored; no restart and no error.
- No arithmetic is performed; elements pass through unchanged at DATA_WIDTH.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `valid_out`=0, `busy`=0, `done`=0, `wr_err`=0. State returns to IDLE and t returns to 0.
- All outputs are registered.
- Latency:
  - `start` sampled at edge k → beat t=0 on outputs after edge k+1.
  - `busy` is high from edge k through the end of the last beat.
  - `valid_out` is high for exactly 3N−2 consecutive cycles when there is no stall.
- A write sampled at edge k is visible to any stream started at edge k+1 or later.
- `done` is high for one cycle, in the first cycle in which `valid_out` is low after the stream.
- Reset mid-stream: outputs go to 0 immediately (asynchronous). No `done` is produced. Stored operands are cleared.

## Configuration
- `SYSTOLIC_FEEDER_STALL_EN` defined:
  - `stall` high in STREAM holds t and keeps the current beat values on the outputs, with `valid_out` driven low for the stalled cycles.
  - The stream resumes with the next beat on the cycle after `stall` deasserts.
  - `stall` has no effect in IDLE.
- Not defined: `stall` is ignored (the port remains, unconnected internally), and the stream always runs 3N−2 back-to-back beats.

## Test plan
All scenarios use N=3, DATA_WIDTH=8, A rows {1,2,3},{4,5,6},{7,8,9} and B rows {10,11,12},{13,14,15},{16,17,18}.

- Basic stream: write A and B, then pulse `start`.
  - A lanes per beat: (1,0,0), (2,4,0), (3,5,7), (0,6,8), (0,0,9), (0,0,0), (0,0,0).
  - B lanes per beat: (10,0,0), (13,11,0), (16,14,12), (0,17,15), (0,0,18), (0,0,0), (0,0,0).
  - `valid_out` high for 7 cycles; `done` pulses once, one cycle after the last beat.
- Write during stream: `wr_en` on beat 2 → `wr_err` pulses; the current and next stream outputs use the original data.
- Simultaneous `start` and `wr_en` in IDLE: the write lands and no stream starts (`busy` stays 0). A later `start` streams the new data.
- Async reset asserted on beat 3: all outputs are 0 within the reset cycle. A new `start` after rewriting the operands yields beat 0 = A (1,0,0).
- With `SYSTOLIC_FEEDER_STALL_EN`: `stall` high for 2 cycles at beat 2 → `valid_out` low for 2 cycles. The 7 beats still appear in order, and `done` is 2 cycles later than in the unstalled case.
